btn_conditioner: RTL and testbench

- Conditions the raw push-button inputs (move right, move left, shoot, continue) before they reach player and game_ctrl.
- Per button: 2-flop synchroniser, counter-based debounce, one-cycle press/release pulses and optional hold-to-repeat press pulses.
- Runs on the 94.5 MHz system clock; player and game_ctrl consume its outputs in place of the raw pins.

---
 rtl/btn_conditioner.sv | 156 +++++++++++++++
 tb/tb_btn_conditioner.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/btn_conditioner.sv
// ============================================================================
// btn_conditioner: per-button synchroniser, debounce, press/release pulses and
// hold-to-repeat press pulses for the game push-buttons.
// Revision: 1.0
// ============================================================================
`default_nettype none

module btn_conditioner #(
  parameter int                 NUM_BTN       = 4,
  parameter int                 DB_CYCLES     = 945000,
  parameter int                 REPEAT_DELAY  = 37800000,
  parameter int                 REPEAT_PERIOD = 9450000,
  parameter logic [NUM_BTN-1:0] REPEAT_MASK   = 4'b0011,
  parameter int                 CNT_W         = 27
) (
  input  logic               clk,
  input  logic               clk_rst,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release,
  output logic               any_press
);

  localparam logic [CNT_W-1:0] C_DB_LAST     = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] C_PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);
  localparam logic [CNT_W-1:0] C_ONE         = CNT_W'(1);

  typedef enum logic [1:0] {
    RP_IDLE   = 2'd0,
    RP_HOLD   = 2'd1,
    RP_REPEAT = 2'd2
  } rp_state_e;

  logic [NUM_BTN-1:0] press_next;
  logic               any_press_q;
  logic               any_press_d;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
    logic [CNT_W-1:0] rp_cnt_q, rp_cnt_d;
    rp_state_e        rp_state_q, rp_state_d;
    logic             level_rise, level_fall, rp_tick;

    always_comb begin
      sync1_d    = btn_raw[i];
      sync2_d    = sync1_q;
      level_d    = level_q;
      db_cnt_d   = db_cnt_q + C_ONE;
      rp_state_d = rp_state_q;
      rp_cnt_d   = rp_cnt_q;
      rp_tick    = 1'b0;

      if (sync2_q == level_q) begin
        db_cnt_d = '0;
      end else if (db_cnt_q == C_DB_LAST) begin
        level_d  = sync2_q;
        db_cnt_d = '0;
      end

      level_rise = level_d & ~level_q;
      level_fall = ~level_d & level_q;

      // A release always takes priority over a coincident repeat tick.
      case (rp_state_q)
        RP_IDLE: begin
          if (level_rise && REPEAT_MASK[i]) begin
            rp_state_d = RP_HOLD;
            rp_cnt_d   = '0;
          end
        end
        RP_HOLD: begin
          if (level_fall) begin
            rp_state_d = RP_IDLE;
            rp_cnt_d   = '0;
          end else if (rp_cnt_q == C_DELAY_LAST) begin
            rp_tick    = 1'b1;
            rp_state_d = RP_REPEAT;
            rp_cnt_d   = '0;
          end else begin
            rp_cnt_d = rp_cnt_q + C_ONE;
          end
        end
        RP_REPEAT: begin
          if (level_fall) begin
            rp_state_d = RP_IDLE;
            rp_cnt_d   = '0;
          end else if (rp_cnt_q == C_PERIOD_LAST) begin
            rp_tick  = 1'b1;
            rp_cnt_d = '0;
          end else begin
            rp_cnt_d = rp_cnt_q + C_ONE;
          end
        end
        default: begin
          rp_state_d = RP_IDLE;
          rp_cnt_d   = '0;
        end
      endcase

      press_d   = level_rise | rp_tick;
      release_d = level_fall;
    end

    always_ff @(posedge clk or negedge clk_rst) begin
      if (!clk_rst) begin
        sync1_q    <= 1'b0;
        sync2_q    <= 1'b0;
        level_q    <= 1'b0;
        press_q    <= 1'b0;
        release_q  <= 1'b0;
        db_cnt_q   <= '0;
        rp_cnt_q   <= '0;
        rp_state_q <= RP_IDLE;
      end else begin
        sync1_q    <= sync1_d;
        sync2_q    <= sync2_d;
        level_q    <= level_d;
        press_q    <= press_d;
        release_q  <= release_d;
        db_cnt_q   <= db_cnt_d;
        rp_cnt_q   <= rp_cnt_d;
        rp_state_q <= rp_state_d;
      end
    end

    assign press_next[i]  = press_d;
    assign btn_level[i]   = level_q;
    assign btn_press[i]   = press_q;
    assign btn_release[i] = release_q;
  end

  // Registered from the next-state presses so it lines up with btn_press.
  always_comb begin
    any_press_d = |press_next;
  end

  always_ff @(posedge clk or negedge clk_rst) begin
    if (!clk_rst) begin
      any_press_q <= 1'b0;
    end else begin
      any_press_q <= any_press_d;
    end
  end

  assign any_press = any_press_q;

endmodule

`default_nettype wire

// File: tb/tb_btn_conditioner.sv
// ============================================================================
// tb_btn_conditioner: scoreboard bench for btn_conditioner with a window-based
// reference model of debounce and arithmetic repeat scheduling.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_btn_conditioner;

  localparam int         NB   = 4;
  localparam int         DB   = 4;
  localparam int         RD   = 10;
  localparam int         RP   = 3;
  localparam int         CW   = 27;
  localparam logic [3:0] MASK = 4'b0011;

  logic          clk = 1'b0;
  logic          clk_rst;
  logic [NB-1:0] btn_raw;
  logic [NB-1:0] btn_level;
  logic [NB-1:0] btn_press;
  logic [NB-1:0] btn_release;
  logic          any_press;

  always #5 clk = ~clk;

  btn_conditioner #(
    .NUM_BTN      (NB),
    .DB_CYCLES    (DB),
    .REPEAT_DELAY (RD),
    .REPEAT_PERIOD(RP),
    .REPEAT_MASK  (MASK),
    .CNT_W        (CW)
  ) dut (
    .clk        (clk),
    .clk_rst    (clk_rst),
    .btn_raw    (btn_raw),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .any_press  (any_press)
  );

  typedef struct packed {
    logic [NB-1:0] lvl;
    logic [NB-1:0] prs;
    logic [NB-1:0] rel;
    logic          any;
  } obs_t;

  obs_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // hist[j] is the raw value sampled j edges ago; the synchroniser makes the
  // debounce see hist[2], so a level is accepted when hist[2..DB+1] agree.
  logic [NB-1:0] hist[DB+2];
  logic [NB-1:0] m_lvl;
  int            start_n[NB];
  int            n = 0;

  task automatic model_edge(input logic [NB-1:0] raw, input logic in_rst);
    obs_t e;
    e = '0;
    if (in_rst) begin
      for (int j = 0; j < DB + 2; j++) hist[j] = '0;
      m_lvl = '0;
    end else begin
      for (int j = DB + 1; j > 0; j--) hist[j] = hist[j-1];
      hist[0] = raw;
      n++;
      for (int b = 0; b < NB; b++) begin
        logic all1, all0, was;
        int   d;
        all1 = 1'b1;
        all0 = 1'b1;
        for (int j = 2; j < DB + 2; j++) begin
          if (!hist[j][b]) all1 = 1'b0;
          if (hist[j][b])  all0 = 1'b0;
        end
        was = m_lvl[b];
        d   = n - start_n[b];
        if (!was && all1) begin
          m_lvl[b]   = 1'b1;
          e.prs[b]   = 1'b1;
          start_n[b] = n;
        end else if (was && all0) begin
          m_lvl[b] = 1'b0;
          e.rel[b] = 1'b1;
        end else if (was && MASK[b] && d >= RD && ((d - RD) % RP) == 0) begin
          e.prs[b] = 1'b1;
        end
      end
      e.lvl = m_lvl;
      e.any = |e.prs;
    end
    exp_q.push_back(e);
  endtask

  task automatic step(input logic [NB-1:0] raw);
    btn_raw = raw;
    @(posedge clk);
    model_edge(raw, !clk_rst);
    #1;
  endtask

  task automatic hold(input logic [NB-1:0] raw, input int cyc);
    repeat (cyc) step(raw);
  endtask

  task automatic assert_reset_now();
    exp_q.delete();
    clk_rst = 1'b0;
    #1;
    total++;
    if ({btn_level, btn_press, btn_release, any_press} !== '0) begin
      bad++;
      $display("FAIL async_reset_clear got lvl=%b prs=%b rel=%b any=%b want all 0",
               btn_level, btn_press, btn_release, any_press);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        obs_t e, a;
        e = exp_q.pop_front();
        a = {btn_level, btn_press, btn_release, any_press};
        total++;
        if (a !== e) begin
          bad++;
          $display("FAIL outputs t=%0t got lvl=%b prs=%b rel=%b any=%b want lvl=%b prs=%b rel=%b any=%b",
                   $time, a.lvl, a.prs, a.rel, a.any, e.lvl, e.prs, e.rel, e.any);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NB-1:0] r;
    for (int b = 0; b < NB; b++) start_n[b] = 0;
    clk_rst = 1'b0;
    btn_raw = '1;

    // held through reset, then re-qualified as a new press
    hold(4'b1111, 3);
    clk_rst = 1'b1;
    hold(4'b1111, 12);
    hold(4'b0000, 10);

    // short pulse rejected, DB-long pulse accepted
    hold(4'b0100, 3);
    hold(4'b0000, 10);
    hold(4'b0100, 4);
    hold(4'b0000, 10);

    // bounce on bit 0
    step(4'b0001); step(4'b0000); step(4'b0001);
    step(4'b0001); step(4'b0000); step(4'b0001);
    hold(4'b0001, 8);
    hold(4'b0000, 8);

    // repeating movement button, then masked button
    hold(4'b0010, 40);
    hold(4'b0000, 8);
    hold(4'b1000, 40);
    hold(4'b0000, 8);

    // level fall lands on the second repeat terminal count
    hold(4'b0001, 13);
    hold(4'b0000, 10);

    // reset in the middle of REPEAT
    hold(4'b0010, 20);
    assert_reset_now();
    hold(4'b0000, 3);
    clk_rst = 1'b1;
    hold(4'b0000, 8);

    // random run lengths around the debounce window
    r = '0;
    for (int c = 0; c < 600; c++) begin
      for (int b = 0; b < NB; b++) begin
        if ($urandom_range(0, 6) == 0) r[b] = ~r[b];
      end
      step(r);
    end
    hold(4'b0000, 10);

    for (int k = 0; k < 5 && exp_q.size() != 0; k++) begin
      @(negedge clk);
      #1;
    end
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain got pending=%0d want 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
